// File: rtl/despread_pkg.sv
// despread_pkg: shared spreading factor, despreader state type and majority decision.
package despread_pkg;
  localparam int SPREAD_CHIPS = 24;
  typedef enum logic {GEN, RUN} state_t;
  function automatic logic [1:0] majority(input int acc, input int spread);
    return {acc > spread / 2, acc * 2 == spread};
  endfunction
endpackage

// File: rtl/despread_corr.sv
// despread_corr: per-symbol ones accumulator and majority decision.
// Ports: i_en accepted chip, i_e chip xor code, i_align restart at this chip,
// i_last final chip of symbol, o_sum acc_next, o_bit/o_tie decision on o_sum.
module despread_corr import despread_pkg::*; #(
  parameter int SPREAD   = SPREAD_CHIPS,
  parameter int SIZE_ACC = $clog2(SPREAD + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic                i_e,
  input  logic                i_align,
  input  logic                i_last,
  output logic [SIZE_ACC-1:0] o_sum,
  output logic                o_bit,
  output logic                o_tie
);
  logic [SIZE_ACC-1:0] acc;
  always_comb begin
    o_sum = (i_align ? '0 : acc) + SIZE_ACC'(i_e);
    {o_bit, o_tie} = majority(int'(o_sum), SPREAD);
  end
  always_ff @(posedge i_clk)
    if (i_reset) acc <= '0;
    else if (i_en) acc <= i_last ? '0 : o_sum;
endmodule

// File: rtl/lfsr.sv
// lfsr: 8-bit Fibonacci PN generator shared by the spreader and the despreader.
// Ports: i_clk, i_reset (sync, active-high), i_valid advances one step, o_data current PN bit.
module lfsr (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_valid,
  output logic o_data
);
  logic [7:0] r;
  always_ff @(posedge i_clk)
    if (i_reset) r <= 8'hA5;
    else if (i_valid) r <= {r[0] ^ r[2] ^ r[3] ^ r[4], r[7:1]};
  assign o_data = r[0];
endmodule

// File: rtl/despread.sv
// despread: XORs received chips with the local PN code and majority-decides one bit per SPREAD chips.
// Ports: i_clk, i_reset (sync, active-high); chip input i_chip/i_valid/o_ready with i_align marking chip 0;
// decision output o_data/o_tie/o_valid with i_ready. DESPREAD_SOFT_EN adds o_corr (ones count of the symbol).
module despread import despread_pkg::*; #(
  parameter int SPREAD       = SPREAD_CHIPS,
  parameter int SIZE_COUNTER = $clog2(SPREAD),
  parameter int SIZE_ACC     = $clog2(SPREAD + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_chip,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_align,
  output logic                o_data,
  output logic                o_tie,
  output logic                o_valid,
`ifdef DESPREAD_SOFT_EN
  output logic [SIZE_ACC-1:0] o_corr,
`endif
  input  logic                i_ready
);
  localparam logic [SIZE_COUNTER-1:0] LAST = SIZE_COUNTER'(SPREAD - 1);
  state_t                state;
  logic [SIZE_COUNTER-1:0] idx, eff;
  logic [SPREAD-1:0]     code;
  logic [SIZE_ACC-1:0]   sum;
  logic                  gen, pn, e, last, at_end, accept, bit_d, tie_d;
  lfsr u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (gen),
    .o_data  (pn)
  );
  despread_corr #(.SPREAD(SPREAD), .SIZE_ACC(SIZE_ACC)) u_corr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (accept),
    .i_e     (e),
    .i_align (i_align),
    .i_last  (last),
    .o_sum   (sum),
    .o_bit   (bit_d),
    .o_tie   (tie_d)
  );
  always_comb begin
    gen = state == GEN;
    at_end = idx == LAST;
    eff = i_align ? '0 : idx;
    last = eff == LAST;
    e = i_chip ^ code[eff];
    // only a symbol's final chip waits, and only while the previous bit is unconsumed
    o_ready = !gen && !(at_end && o_valid && !i_ready);
    accept = i_valid && o_ready;
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state <= GEN;
      idx <= '0;
      code <= '0;
      o_valid <= 1'b0;
      o_data <= 1'b0;
      o_tie <= 1'b0;
`ifdef DESPREAD_SOFT_EN
      o_corr <= '0;
`endif
    end else if (gen) begin
      code[idx] <= pn;
      idx <= at_end ? '0 : idx + 1'b1;
      if (at_end) state <= RUN;
    end else begin
      if (accept) idx <= last ? '0 : eff + 1'b1;
      if (accept && last) begin
        o_valid <= 1'b1;
        o_data <= bit_d;
        o_tie <= tie_d;
`ifdef DESPREAD_SOFT_EN
        o_corr <= sum;
`endif
      end else if (o_valid && i_ready) o_valid <= 1'b0;
    end
endmodule

// File: tb/tb_despread.sv
// tb_despread: directed self-checking bench for despread.
module tb_despread;
  import despread_pkg::*;
  localparam int S  = SPREAD_CHIPS;
  localparam int SA = $clog2(S + 1);
  logic i_clk = 0, i_reset = 1, i_chip = 0, i_valid = 0, i_align = 0, i_ready = 1;
  logic o_ready, o_data, o_tie, o_valid;
`ifdef DESPREAD_SOFT_EN
  logic [SA-1:0] o_corr;
`endif
  int errors = 0, checks = 0, zeros, stall_n, stall_at, g, rcv, hold;
  bit seen;
  logic st;
  logic [S-1:0] code;
  logic [7:0] m;
  logic [3:0] bits, got;
  always #5 i_clk = ~i_clk;
  despread dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_chip  (i_chip),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_align (i_align),
    .o_data  (o_data),
    .o_tie   (o_tie),
    .o_valid (o_valid),
`ifdef DESPREAD_SOFT_EN
    .o_corr  (o_corr),
`endif
    .i_ready (i_ready)
  );
  task automatic chk1(input string tag, input logic got_v, input logic exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s got=%b expected=%b", tag, got_v, exp_v);
    end
  endtask
  task automatic chkn(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got_v, exp_v);
    end
  endtask
  task automatic corr_chk(input string tag, input int exp_v);
`ifdef DESPREAD_SOFT_EN
    chkn(tag, 32'(o_corr), exp_v);
`endif
  endtask
  task automatic check_out(input string tag, input logic d, input logic t, input int c);
    chk1({tag, "_valid"}, o_valid, 1'b1);
    chk1({tag, "_data"}, o_data, d);
    chk1({tag, "_tie"}, o_tie, t);
    corr_chk({tag, "_corr"}, c);
  endtask
  // called at posedge+1, returns at posedge+1 after the chip has transferred
  task automatic put_chip(input logic c, input logic al, output logic stalled);
    stalled = 0;
    i_chip = c;
    i_valid = 1;
    i_align = al;
    #1;
    for (int n = 0; !o_ready; n++) begin
      if (n == 200) begin
        chk1("ready_timeout", o_ready, 1'b1);
        break;
      end
      stalled = 1;
      @(posedge i_clk);
      #2;
    end
    @(posedge i_clk);
    #1;
    i_valid = 0;
    i_align = 0;
  endtask
  task automatic send_sym(input logic b, input logic [S-1:0] fl, input logic gap);
    logic s;
    for (int k = 0; k < S; k++) begin
      put_chip(code[k] ^ b ^ fl[k], 1'b0, s);
      if (gap && k < S - 1) begin
        i_chip = ~i_chip;
        @(posedge i_clk);
        #1;
      end
    end
  endtask
  task automatic wait_gen(input string tag);
    zeros = 0;
    for (int n = 0; n < 40 && !o_ready; n++) begin
      zeros++;
      @(posedge i_clk);
      #1;
      i_chip = ~i_chip;
    end
    chkn(tag, zeros, S);
  endtask
  task automatic idle();
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    m = 8'hA5;
    for (int k = 0; k < S; k++) begin
      code[k] = m[0];
      m = {m[0] ^ m[2] ^ m[3] ^ m[4], m[7:1]};
    end
    i_valid = 1;
    i_chip = 1;
    repeat (2) @(posedge i_clk);
    #1;
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_data", o_data, 1'b0);
    chk1("rst_tie", o_tie, 1'b0);
    chk1("rst_ready", o_ready, 1'b0);
    corr_chk("rst_corr", 0);
    i_reset = 0;
    wait_gen("gen_len");
    chk1("gen_no_out", o_valid, 1'b0);
    i_valid = 0;
    for (int k = 0; k < S - 1; k++) put_chip(~code[k], 1'b0, st);
    chk1("pre_last_valid", o_valid, 1'b0);
    put_chip(~code[S-1], 1'b0, st);
    check_out("bit1", 1'b1, 1'b0, 24);
    idle();
    chk1("drop_after_xfer", o_valid, 1'b0);
    send_sym(1'b0, 24'h00001F, 1'b0);
    check_out("flip5", 1'b0, 1'b0, 5);
    idle();
    send_sym(1'b0, 24'h0007FF, 1'b1);
    check_out("flip11_gaps", 1'b0, 1'b0, 11);
    idle();
    send_sym(1'b0, 24'h000FFF, 1'b0);
    check_out("flip12", 1'b0, 1'b1, 12);
    idle();
    i_ready = 0;
    send_sym(1'b1, 24'h0, 1'b0);
    for (int k = 0; k < 10; k++) put_chip(~code[k], 1'b0, st);
    i_reset = 1;
    idle();
    chk1("midrst_valid", o_valid, 1'b0);
    chk1("midrst_data", o_data, 1'b0);
    chk1("midrst_ready", o_ready, 1'b0);
    i_reset = 0;
    i_ready = 1;
    wait_gen("regen_len");
    for (int k = 0; k < S; k++) put_chip(code[k] ^ (k < 3), k == 0, st);
    check_out("post_rst", 1'b0, 1'b0, 3);
    idle();
    for (int k = 0; k < 7; k++) put_chip(~code[k], 1'b0, st);
    for (int k = 0; k < S; k++) begin
      put_chip(code[k] ^ (k < 2), k == 0, st);
      if (k == 16) chk1("align_no_early", o_valid, 1'b0);
    end
    check_out("align7", 1'b0, 1'b0, 2);
    idle();
    bits = 4'b1101;
    got = '0;
    stall_n = 0;
    stall_at = -1;
    g = 0;
    rcv = 0;
    hold = 0;
    seen = 0;
    fork
      begin
        for (int s = 0; s < 4; s++)
          for (int k = 0; k < S; k++) begin
            put_chip(code[k] ^ bits[s], 1'b0, st);
            if (st) begin
              stall_n++;
              stall_at = g;
            end
            g++;
          end
      end
      begin
        for (int c = 0; c < 400 && rcv < 4; c++) begin
          @(posedge i_clk);
          #1;
          if (o_valid && !seen) begin
            seen = 1;
            hold = 40;
          end
          i_ready = hold == 0;
          if (hold > 0) hold--;
          #1;
          if (o_valid && i_ready) begin
            got[rcv] = o_data;
            rcv++;
          end
        end
      end
    join
    chkn("b2b_stall_chips", stall_n, 1);
    chkn("b2b_stall_at", stall_at, S + S - 1);
    chkn("b2b_delivered", rcv, 4);
    for (int s = 0; s < 4; s++) chk1($sformatf("b2b_bit%0d", s), got[s], bits[s]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
